// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through output
// (head word shown combinationally while not empty). Without it, data_out
// is a register loaded on each accepted read (1-cycle read latency).
//
// Handshake: a write is accepted on a rising edge when wr_en=1 and the
// registered full flag is 0; a read is accepted when rd_en=1 and the
// registered empty flag is 0. full/empty act as the inverse of ready; a
// request against a blocked side is dropped and reported by a one-cycle
// overflow/underflow pulse, with no other side effect.

module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CW-1:0]     w_count_nxt;

  // Acceptance is decided from this cycle's registered flags only.
  assign w_wr_acc = wr_en && !r_full;
  assign w_rd_acc = rd_en && !r_empty;

  // Next occupancy: a simultaneous read and write cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count, status flags and error pulses; flags track next count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count        <= w_count_nxt;
      r_empty        <= (w_count_nxt == '0);
      r_full         <= (w_count_nxt == DEPTH_C);
      r_almost_full  <= (w_count_nxt >= AF_C);
      r_almost_empty <= (w_count_nxt <= AE_C);
      r_overflow     <= wr_en && r_full;
      r_underflow    <= rd_en && r_empty;
    end
  end

  // Storage array; deliberately not reset, stale words are unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; drive zero while nothing is stored.
  assign data_out = r_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [DATA_W-1:0] r_data_out;

  // Registered output: load the head word on an accepted read, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_data_out <= '0;
    else if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
  end

  assign data_out = r_data_out;
`endif

  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed self-checking bench for fifo_sync_param with
// default parameters (DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2).
// Works for both the registered-output and FIFO_FWFT_EN builds.

module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  // Scoreboard: words the FIFO should hold, oldest first.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_pop = '0;

  fifo_sync_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one write cycle; the model accepts only when it is not full.
  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1;
    data_in = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  // Driver: one read cycle; returns what the FIFO presented for that read.
  task automatic pop(output logic [DW-1:0] got, output logic [DW-1:0] exp);
    exp = '0;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      last_pop = exp;
    end
    rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
    got = data_out;
    tick();
`else
    tick();
    got = data_out;
`endif
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
    checks++; if ({full, almost_full, overflow, underflow} !== 4'b0) begin
      errors++; $display("FAIL reset_others got=%b exp=0000", {full, almost_full, overflow, underflow});
    end
    rst = 1'b1;
    tick();
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL idle_after_release empty=%b count=%0d exp empty=1 count=0", empty, count);
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] got, exp;
    logic [4:0]    n;
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i));
      n = 5'(i + 1);
      checks++; if (count !== n) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", count, n); end
      checks++; if (almost_full !== (n >= 5'(AF))) begin
        errors++; $display("FAIL fill_af count=%0d got=%b exp=%b", n, almost_full, (n >= 5'(AF)));
      end
      checks++; if (almost_empty !== (n <= 5'(AE))) begin
        errors++; $display("FAIL fill_ae count=%0d got=%b exp=%b", n, almost_empty, (n <= 5'(AE)));
      end
      checks++; if (full !== (n == 5'(DEPTH)) || empty !== 1'b0) begin
        errors++; $display("FAIL fill_flags count=%0d full=%b empty=%b", n, full, empty);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      pop(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL drain_data got=%h exp=%h", got, exp); end
      checks++; if (count !== 5'(DEPTH - 1 - i)) begin
        errors++; $display("FAIL drain_count got=%0d exp=%0d", count, DEPTH - 1 - i);
      end
    end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL drain_end empty=%b full=%b exp empty=1 full=0", empty, full);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] got, exp;
    for (int i = 0; i < DEPTH; i++) push(8'h20 + 8'(i));
    push(8'hAA);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL ovf_count got=%0d full=%b exp=16 full=1", count, full);
    end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      pop(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL ovf_drain got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] exp_d;
`ifdef FIFO_FWFT_EN
    exp_d = '0;
`else
    exp_d = last_pop;
`endif
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%b exp=1", underflow); end
    checks++; if (data_out !== exp_d) begin errors++; $display("FAIL udf_data got=%h exp=%h", data_out, exp_d); end
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL udf_count got=%0d empty=%b exp=0 empty=1", count, empty);
    end
    tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_one_cycle got=%b exp=0", underflow); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] got, exp, nxt;
    nxt = 8'h40;
    for (int i = 0; i < 8; i++) begin push(nxt); nxt++; end
    // 40 cycles of read+write: count stays 8, order survives pointer wrap.
    for (int i = 0; i < 40; i++) begin
      exp = exp_q.pop_front();
      exp_q.push_back(nxt);
      wr_en = 1'b1; rd_en = 1'b1; data_in = nxt;
`ifdef FIFO_FWFT_EN
      got = data_out;
      tick();
`else
      tick();
      got = data_out;
`endif
      nxt++;
      checks++; if (got !== exp) begin errors++; $display("FAIL both_data cyc=%0d got=%h exp=%h", i, got, exp); end
      checks++; if (count !== 5'd8) begin errors++; $display("FAIL both_count cyc=%0d got=%0d exp=8", i, count); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL both_drain got=%h exp=%h", got, exp); end
    end
    // Full with both requests: only the read is taken.
    for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i));
    exp = exp_q.pop_front();
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hBB;
`ifdef FIFO_FWFT_EN
    got = data_out;
    tick();
`else
    tick();
    got = data_out;
`endif
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (got !== exp) begin errors++; $display("FAIL full_both_data got=%h exp=%h", got, exp); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_both_ovf got=%b exp=1", overflow); end
    checks++; if (count !== 5'd15 || full !== 1'b0) begin
      errors++; $display("FAIL full_both_count got=%0d full=%b exp=15 full=0", count, full);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      pop(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL full_both_drain got=%h exp=%h", got, exp); end
    end
    // Empty with both requests: only the write is taken.
    exp_q.push_back(8'hC3);
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hC3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_both_udf got=%b exp=1", underflow); end
    checks++; if (count !== 5'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL empty_both_count got=%0d empty=%b exp=1 empty=0", count, empty);
    end
    pop(got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL empty_both_data got=%h exp=%h", got, exp); end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] got, exp;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL ares_pre_count got=%0d exp=5", count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin
      errors++; $display("FAIL ares_immediate count=%0d empty=%b ae=%b exp 0/1/1", count, empty, almost_empty);
    end
    checks++; if ({full, almost_full, overflow, underflow} !== 4'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL ares_outputs flags=%b data=%h exp 0000/00", {full, almost_full, overflow, underflow}, data_out);
    end
    exp_q.delete();
    last_pop = '0;
    tick();
    rst = 1'b1;
    tick();
    push(8'h5A);
`ifdef FIFO_FWFT_EN
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL ares_fwft_head got=%h exp=5a", data_out); end
`endif
    pop(got, exp);
    checks++; if (got !== 8'h5A) begin errors++; $display("FAIL ares_readback got=%h exp=5a", got); end
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL ares_end empty=%b count=%0d exp 1/0", empty, count);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous single-clock FIFO; next generation of the team's 8-bit FIFO. Generalises data width and depth, adds occupancy count, programmable almost-full/almost-empty thresholds and sticky-free overflow/underflow error pulses. Sits between a producer and consumer in the same `clk` domain; drop-in for the 8-bit FIFO when `DATA_W=8`.

## Interface
- `DATA_W`, 8, data word width in bits (>=1)
- `DEPTH`, 16, number of entries; power of two, >=4
- `AF_THRESH`, 14, `almost_full` asserted when count >= this value (1..DEPTH-1)
- `AE_THRESH`, 2, `almost_empty` asserted when count <= this value (1..DEPTH-1)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous active-low reset (asserted when 0)
- `wr_en`  in  1  write request
- `rd_en`  in  1  read request
- `data_in`  in  DATA_W  write data
- `data_out`  out  DATA_W  read data
- `empty`  out  1  no entries stored
- `full`  out  1  DEPTH entries stored
- `almost_full`  out  1  count >= AF_THRESH
- `almost_empty`  out  1  count <= AE_THRESH
- `count`  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `overflow`  out  1  one-cycle pulse: write requested while full
- `underflow`  out  1  one-cycle pulse: read requested while empty

## Operation
- Storage: DEPTH x DATA_W array, not reset. Pointers `wr_ptr`, `rd_ptr` are clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Write accepted iff `wr_en && !full`; stores `data_in` at `wr_ptr`, increments `wr_ptr`.
- Read accepted iff `rd_en && !empty`; advances `rd_ptr`.
- Acceptance uses the registered `full`/`empty` of the current cycle; no write-through-when-full, no read-through-when-empty.
- `count` next value: +1 on write only, -1 on read only, unchanged on both or neither. Never leaves 0..DEPTH.
- `empty`, `full`, `almost_full`, `almost_empty` are registered and derived from next `count`; all change on the same edge as `count`.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Full with `wr_en && rd_en`: read accepted, write rejected, `overflow` pulses.
- Empty with `wr_en && rd_en`: write accepted, read rejected, `underflow` pulses.
- `overflow`/`underflow` are registered, high for exactly the cycle after the offending request edge; a rejected request has no other side effect.
- Standard mode data: `data_out` is a register loaded with `mem[rd_ptr]` on an accepted read; holds its value otherwise.

## Timing
- Reset (`rst`=0, async): pointers, `count`, `data_out`, `full`, `almost_full`, `overflow`, `underflow` -> 0; `empty`, `almost_empty` -> 1. Takes effect immediately, independent of `clk`; release is synchronous on the next rising edge.
- Reset mid-operation discards all contents; memory array keeps stale data but is unreachable.
- Write-to-`empty`-deassert: 1 cycle (flag low after the accepting edge).
- Standard mode read latency: 1 cycle; data valid after the edge that accepts `rd_en`.
- Write-to-read: a word written at edge N is readable (request at edge N+1, data after edge N+1).
- `full` asserts after the edge accepting the DEPTH-th write; deasserts after the first accepting read edge.

## Configuration
- `FIFO_FWFT_EN` defined: first-word-fall-through. `data_out` is combinationally `mem[rd_ptr]` whenever `!empty` (head word visible with zero latency); `rd_en` acknowledges/pops it. `data_out` undefined-but-stable (drive 0) while `empty`. Flags, count and error pulses unchanged.
- `FIFO_FWFT_EN` undefined: standard registered-output mode described above.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles -> `empty`=1, `almost_empty`=1, `count`=0, `data_out`=0, all other outputs 0.
- Fill/drain, DATA_W=8, DEPTH=16: write 0x00..0x0F -> `full`=1, `count`=16, `almost_full` from count 14; read 16 -> data 0x00..0x0F in order, `empty`=1 at end.
- Overflow: full, write 0xAA -> `overflow` high one cycle, `count` stays 16, subsequent reads never return 0xAA.
- Underflow: empty, `rd_en`=1 -> `underflow` high one cycle, `data_out` unchanged, `count`=0.
- Simultaneous and wrap-around: hold count=8, assert `wr_en`+`rd_en` for 40 cycles with incrementing data -> `count` constant 8, output sequence strictly in order across pointer wrap; full + both -> read only plus `overflow`.
- Async reset mid-stream with count=5 -> outputs at reset values before next edge; after release, first write 0x5A reads back 0x5A (FWFT build: visible on `data_out` one cycle after write).
